reg_dump: RTL

REG_DUMP -- requirements
Module: reg_dump

---
 rtl/reg_dump_pkg.sv | 25 ++
 rtl/reg_dump_if.sv | 25 ++
 rtl/reg_dump_ser.sv | 44 ++++
 rtl/reg_dump.sv | 122 ++++++++++++
 4 files changed

// File: rtl/reg_dump_pkg.sv
// Shared constants, FSM state encoding and checksum helper for the register dump block.
// Optional checksum trailer is enabled by defining REG_DUMP_CKSUM_EN.
package reg_dump_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int BYTE_W     = 8;
    localparam int CKSUM_W    = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_SEND  = 3'd2,
`ifdef REG_DUMP_CKSUM_EN
        ST_CKSUM = 3'd3,
`endif
        ST_DONE  = 3'd4
    } state_t;

    // XOR of the four bytes of a word; folding per word equals XOR over the byte stream.
    function automatic logic [CKSUM_W-1:0] xor_bytes(input logic [REG_DATA_W-1:0] w);
        return w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
    endfunction

endpackage

// File: rtl/reg_dump_if.sv
// Bus bundle between the register dump block, the core register file and the serial transmitter.
interface reg_dump_if;
    import reg_dump_pkg::*;

    logic                  start;
    logic [REG_ADDR_W-1:0] rd_reg;
    logic [REG_DATA_W-1:0] rd_data;
    logic [BYTE_W-1:0]     tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic                  busy;
    logic                  stall;
    logic                  done;

    modport slave (
        input  start, rd_data, tx_ready,
        output rd_reg, tx_data, tx_valid, busy, stall, done
    );

    modport master (
        output start, rd_data, tx_ready,
        input  rd_reg, tx_data, tx_valid, busy, stall, done
    );

endinterface

// File: rtl/reg_dump_ser.sv
// Word-to-byte serializer: MSB byte first, valid/ready handshake, flags the fourth transfer.
module reg_dump_ser
    import reg_dump_pkg::*;
(
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  load,
    input  logic [REG_DATA_W-1:0] word,
    input  logic                  tx_ready,
    output logic [BYTE_W-1:0]     tx_data,
    output logic                  tx_valid,
    output logic                  word_done
);

    logic [REG_DATA_W-1:0] shift_r;
    logic [1:0]            cnt_r;
    logic                  valid_r;

    // Shift register, byte counter and valid flag; a load always wins over a transfer.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            shift_r <= '0;
            cnt_r   <= 2'd0;
            valid_r <= 1'b0;
        end else if (load) begin
            shift_r <= word;
            cnt_r   <= 2'd0;
            valid_r <= 1'b1;
        end else if (valid_r && tx_ready) begin
            shift_r <= {shift_r[REG_DATA_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
            cnt_r   <= cnt_r + 2'd1;
            valid_r <= (cnt_r != 2'd3);
        end else begin
            shift_r <= shift_r;
            cnt_r   <= cnt_r;
            valid_r <= valid_r;
        end
    end

    assign tx_data   = shift_r[REG_DATA_W-1 -: BYTE_W];
    assign tx_valid  = valid_r;
    assign word_done = valid_r & tx_ready & (cnt_r == 2'd3);

endmodule

// File: rtl/reg_dump.sv
// Register-file dump controller: walks registers FIRST_REG..FIRST_REG+NREG-1 and streams them bytewise.
// Define REG_DUMP_CKSUM_EN to append an XOR checksum byte after the data.
module reg_dump
    import reg_dump_pkg::*;
#(
    parameter int NREG      = 32,
    parameter int FIRST_REG = 0
) (
    input  logic       clk,
    input  logic       rstn,
    reg_dump_if.slave  bus
);

    localparam logic [REG_ADDR_W-1:0] FIRST_IDX = REG_ADDR_W'(FIRST_REG);
    localparam logic [REG_ADDR_W-1:0] LAST_IDX  = REG_ADDR_W'(FIRST_REG + NREG - 1);

    state_t                state_r, state_s;
    logic [REG_ADDR_W-1:0] idx_r, idx_s;
    logic                  load_s;
    logic                  word_done_s;
    logic                  ser_valid_s;
    logic [BYTE_W-1:0]     ser_data_s;
`ifdef REG_DUMP_CKSUM_EN
    logic [CKSUM_W-1:0]    cksum_r, cksum_s;
`endif

    reg_dump_ser u_ser (
        .clk       (clk),
        .rstn      (rstn),
        .load      (load_s),
        .word      (bus.rd_data),
        .tx_ready  (bus.tx_ready),
        .tx_data   (ser_data_s),
        .tx_valid  (ser_valid_s),
        .word_done (word_done_s)
    );

    // Next-state, index and checksum logic.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        load_s  = 1'b0;
`ifdef REG_DUMP_CKSUM_EN
        cksum_s = cksum_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    idx_s   = FIRST_IDX;
                    state_s = ST_FETCH;
`ifdef REG_DUMP_CKSUM_EN
                    cksum_s = '0;
`endif
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                load_s  = 1'b1;
                state_s = ST_SEND;
`ifdef REG_DUMP_CKSUM_EN
                cksum_s = cksum_r ^ xor_bytes(bus.rd_data);
`endif
            end
            ST_SEND: begin
                if (word_done_s && (idx_r == LAST_IDX)) begin
`ifdef REG_DUMP_CKSUM_EN
                    state_s = ST_CKSUM;
`else
                    state_s = ST_DONE;
`endif
                end else if (word_done_s) begin
                    idx_s   = idx_r + 5'd1;
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_SEND;
                end
            end
`ifdef REG_DUMP_CKSUM_EN
            ST_CKSUM: begin
                if (bus.tx_ready) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_CKSUM;
                end
            end
`endif
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State, index and checksum registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
            idx_r   <= FIRST_IDX;
`ifdef REG_DUMP_CKSUM_EN
            cksum_r <= '0;
`endif
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
`ifdef REG_DUMP_CKSUM_EN
            cksum_r <= cksum_s;
`endif
        end
    end

    assign bus.rd_reg = idx_r;
    assign bus.busy   = (state_r != ST_IDLE);
    assign bus.stall  = (state_r != ST_IDLE);
    assign bus.done   = (state_r == ST_DONE);
`ifdef REG_DUMP_CKSUM_EN
    assign bus.tx_valid = ser_valid_s | (state_r == ST_CKSUM);
    assign bus.tx_data  = (state_r == ST_CKSUM) ? cksum_r : ser_data_s;
`else
    assign bus.tx_valid = ser_valid_s;
    assign bus.tx_data  = ser_data_s;
`endif

endmodule
